// File: rtl/line_buf_pkg.sv
// Shared defaults, pixel type and index helpers for the line_buf_window_stream slice.
package line_buf_pkg;

  localparam int KERNEL    = 3;
  localparam int IMG_WIDTH = 28;
  localparam int D_WIDTH   = 16;

  typedef logic [D_WIDTH-1:0] pixel_t;

  // Smallest bit count able to address n entries, never below one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int tap_idx(input int g, input int r, input int c, input int k);
    return (g * k + r) * k + c;
  endfunction

endpackage

// File: rtl/line_buf_channel.sv
// One channel: KERNEL-1 flip-flop line buffers plus the KERNEL x KERNEL window shift register.
module line_buf_channel
  import line_buf_pkg::*;
#(
  parameter int KERNEL    = 3,
  parameter int IMG_WIDTH = 28,
  parameter int D_WIDTH   = 16,
  parameter int COL_BITS  = 5
) (
  input  logic                                clk,
  input  logic                                shift_en,
  input  logic [COL_BITS-1:0]                 col,
  input  logic [D_WIDTH-1:0]                  pixel,
  output logic [KERNEL*KERNEL*D_WIDTH-1:0]    window
);

  logic [D_WIDTH-1:0] lb     [KERNEL-1][IMG_WIDTH];
  logic [D_WIDTH-1:0] win_p0 [KERNEL][KERNEL];
  logic [D_WIDTH-1:0] col_new[KERNEL];

  // Column entering on the right: buffered rows above (oldest first), live pixel at the bottom.
  always_comb begin
    for (int r = 0; r < KERNEL-1; r++) col_new[r] = lb[r][col];
    col_new[KERNEL-1] = pixel;
  end

  // Stage p0: window shifts left, line buffers shift up one row at this column.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int r = 0; r < KERNEL; r++) begin
        for (int c = 0; c < KERNEL-1; c++) win_p0[r][c] <= win_p0[r][c+1];
        win_p0[r][KERNEL-1] <= col_new[r];
      end
      for (int i = 0; i < KERNEL-2; i++) lb[i][col] <= lb[i+1][col];
      lb[KERNEL-2][col] <= pixel;
    end
  end

  for (genvar r = 0; r < KERNEL; r++) begin : g_row
    for (genvar c = 0; c < KERNEL; c++) begin : g_col
      assign window[tap_idx(0, r, c, KERNEL)*D_WIDTH +: D_WIDTH] = win_p0[r][c];
    end
  end

endmodule

// File: rtl/line_buf_window_stream.sv
// Multi-channel line buffer emitting KERNEL x KERNEL windows over valid/ready.
// Optional stride-2 emission when LINE_BUF_STRIDE2_EN is defined.
module line_buf_window_stream #(
  parameter int NUM_CH     = 16,
  parameter int KERNEL     = line_buf_pkg::KERNEL,
  parameter int IMG_WIDTH  = line_buf_pkg::IMG_WIDTH,
  parameter int IMG_HEIGHT = 28,
  parameter int D_WIDTH    = line_buf_pkg::D_WIDTH,
  parameter int COL_BITS   = 5,
  parameter int ROW_BITS   = 5
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NUM_CH*D_WIDTH-1:0]                 in_data,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NUM_CH*KERNEL*KERNEL*D_WIDTH-1:0]   out_window,
  output logic [ROW_BITS-1:0]                       out_row,
  output logic [COL_BITS-1:0]                       out_col,
  output logic                                      frame_done
);

  localparam int WIN_CH = KERNEL*KERNEL*D_WIDTH;
  localparam logic [ROW_BITS-1:0] ROW_START = ROW_BITS'(KERNEL-1);
  localparam logic [COL_BITS-1:0] COL_START = COL_BITS'(KERNEL-1);
  localparam logic [ROW_BITS-1:0] ROW_LAST  = ROW_BITS'(IMG_HEIGHT-1);
  localparam logic [COL_BITS-1:0] COL_LAST  = COL_BITS'(IMG_WIDTH-1);

  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row_p1;
  logic [COL_BITS-1:0] col_p1;
  logic                vld_p1;
  logic                accept, qualify, phase_ok, last_col, last_row;
  logic [NUM_CH*WIN_CH-1:0] win_all;

  assign in_ready = !vld_p1 || out_ready;
  assign accept   = in_valid && in_ready;
  assign last_col = (col == COL_LAST);
  assign last_row = (row == ROW_LAST);

`ifdef LINE_BUF_STRIDE2_EN
  // Even offset from the first full window <=> same LSB as the start position.
  assign phase_ok = (row[0] == ROW_START[0]) && (col[0] == COL_START[0]);
`else
  assign phase_ok = 1'b1;
`endif

  assign qualify = accept && (row >= ROW_START) && (col >= COL_START) && phase_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    line_buf_channel #(
      .KERNEL    (KERNEL),
      .IMG_WIDTH (IMG_WIDTH),
      .D_WIDTH   (D_WIDTH),
      .COL_BITS  (COL_BITS)
    ) u_ch (
      .clk      (clk),
      .shift_en (accept),
      .col      (col),
      .pixel    (in_data[g*D_WIDTH +: D_WIDTH]),
      .window   (win_all[g*WIN_CH +: WIN_CH])
    );
  end

  // Stage p1: window handshake state, raster counters and frame pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      col        <= '0;
      vld_p1     <= 1'b0;
      row_p1     <= '0;
      col_p1     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_col && last_row;
      if (accept) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_BITS'(1);
        end else begin
          col <= col + COL_BITS'(1);
        end
      end
      if (qualify) begin
        vld_p1 <= 1'b1;
        row_p1 <= row;
        col_p1 <= col;
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // The shift register only moves on accept, so it is stable while a window waits.
  assign out_valid  = vld_p1;
  assign out_row    = row_p1;
  assign out_col    = col_p1;
  assign out_window = vld_p1 ? win_all : '0;

endmodule

// File: tb/tb_line_buf_window_stream.sv
// Scoreboard bench for line_buf_window_stream (2 channels, small frame; 6x6 when LINE_BUF_STRIDE2_EN).
`timescale 1ns/1ps
module tb_line_buf_window_stream;
  import line_buf_pkg::*;

`ifdef LINE_BUF_STRIDE2_EN
  localparam int  W = 6;
  localparam int  H = 6;
  localparam bit  STRIDE2 = 1'b1;
`else
  localparam int  W = 4;
  localparam int  H = 4;
  localparam bit  STRIDE2 = 1'b0;
`endif
  localparam int NCH   = 2;
  localparam int K     = 3;
  localparam int DW    = 16;
  localparam int CB    = clog2_min1(W);
  localparam int RB    = clog2_min1(H);
  localparam int WIN_W = NCH*K*K*DW;
  localparam int NWIN  = STRIDE2 ? ((H-K)/2+1)*((W-K)/2+1) : (H-K+1)*(W-K+1);

  logic             clk;
  logic             rst, in_valid, in_ready, out_valid, out_ready, frame_done;
  logic [NCH*DW-1:0] in_data;
  logic [WIN_W-1:0] out_window;
  logic [RB-1:0]    out_row;
  logic [CB-1:0]    out_col;

  line_buf_window_stream #(
    .NUM_CH(NCH), .KERNEL(K), .IMG_WIDTH(W), .IMG_HEIGHT(H),
    .D_WIDTH(DW), .COL_BITS(CB), .ROW_BITS(RB)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_window(out_window), .out_row(out_row), .out_col(out_col),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIN_W-1:0] win;
    int               r;
    int               c;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   m_row, m_col;
  bit   ov_exp, fd_exp;
  int   n_acc, n_hs, n_fd, first_acc;

  task automatic chk(input string tag, input logic [WIN_W-1:0] got, input logic [WIN_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int ch, input int r, input int c);
    return DW'(r*W + c + 100*ch);
  endfunction

  function automatic logic [WIN_W-1:0] model_win(input int r, input int c);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int g = 0; g < NCH; g++)
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          w[tap_idx(g, i, j, K)*DW +: DW] = pix(g, r-(K-1)+i, c-(K-1)+j);
    return w;
  endfunction

  // One clock: drive at negedge, check just after, then advance the reference model.
  task automatic cycle(input logic iv, input logic ordy, input logic rs);
    logic acc, qual;
    @(negedge clk);
    rst       = rs;
    in_valid  = iv;
    out_ready = ordy;
    for (int g = 0; g < NCH; g++) in_data[g*DW +: DW] = pix(g, m_row, m_col);
    #1;
    chk("in_ready", in_ready, !ov_exp || ordy);
    chk("out_valid", out_valid, ov_exp);
    chk("frame_done", frame_done, fd_exp);
    if (frame_done) n_fd++;
    if (out_valid && first_acc == 0) first_acc = n_acc;
    if (out_valid && ordy) n_hs++;
    if (ov_exp && q.size() != 0) begin
      chk("window", out_window, q[0].win);
      chk("out_row", out_row, q[0].r);
      chk("out_col", out_col, q[0].c);
      if (ordy) void'(q.pop_front());
    end
    acc = iv && (!ov_exp || ordy) && !rs;
    if (rs) begin
      m_row = 0; m_col = 0; ov_exp = 0; fd_exp = 0;
      q.delete();
    end else begin
      fd_exp = acc && (m_row == H-1) && (m_col == W-1);
      qual = acc && (m_row >= K-1) && (m_col >= K-1) &&
             (!STRIDE2 || ((((m_row-(K-1)) % 2) == 0) && (((m_col-(K-1)) % 2) == 0)));
      if (qual) begin
        q.push_back('{model_win(m_row, m_col), m_row, m_col});
        ov_exp = 1'b1;
      end else if (ordy) begin
        ov_exp = 1'b0;
      end
      if (acc) begin
        n_acc++;
        if (m_col == W-1) begin
          m_col = 0;
          m_row = (m_row == H-1) ? 0 : m_row + 1;
        end else begin
          m_col = m_col + 1;
        end
      end
    end
  endtask

  // mode 0: continuous, 1: 5-cycle backpressure after first window, 2: random bubbles/stalls
  task automatic run_frame(input int mode);
    int  cyc;
    bit  bp;
    n_acc = 0; n_hs = 0; n_fd = 0; first_acc = 0; cyc = 0; bp = 0;
    while (n_acc < W*H && cyc < 3000) begin
      if (mode == 1 && !bp && ov_exp) begin
        repeat (5) cycle(1'b1, 1'b0, 1'b0);
        bp = 1;
        cyc += 5;
      end else if (mode == 2) begin
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'b0);
      end else begin
        cycle(1'b1, 1'b1, 1'b0);
      end
      cyc++;
    end
    chk("frame_accepts", n_acc, W*H);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    chk("win_count", n_hs, NWIN);
    chk("frame_done_cnt", n_fd, 1);
    chk("first_win_accepts", first_acc, (K-1)*W + K);
    chk("queue_drained", q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
    m_row = 0; m_col = 0; ov_exp = 0; fd_exp = 0;
    n_acc = 0; n_hs = 0; n_fd = 0; first_acc = 0;
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("rst_out_window", out_window, '0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_in_ready", in_ready, 1);

    run_frame(0);
    run_frame(1);

    // Reset after 7 accepted pixels, then a clean frame from (0,0).
    n_acc = 0;
    for (int i = 0; i < 50 && n_acc < 7; i++) cycle(1'b1, 1'b1, 1'b0);
    chk("pre_reset_accepts", n_acc, 7);
    cycle(1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0);
    chk("post_reset_out_valid", out_valid, 0);
    run_frame(0);

    run_frame(2);
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
